axi_txn_timeout_tracker: RTL and testbench
==========================================

AXI_TXN_TIMEOUT_TRACKER -- requirements
Module: axi_txn_timeout_tracker

Interface
REQ-001 SHALL have parameter MaxUniqIds, default 2: maximum number of distinct AXI IDs tracked concurrently.
REQ-002 SHALL have parameter MaxTxnsPerId, default 4: maximum outstanding transactions per tracked ID.
REQ-003 SHALL have parameter CntWidth, default 10: width of each timeout budget counter.
REQ-004 SHALL have parameter PrescalerDiv, default 64: clock cycles per timeout tick; legal range is at least 2.
REQ-005 SHALL have parameter AxiIdWidth, default 6: width of the AXI ID.
REQ-006 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-007 SHALL have port rst_ni, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port budget_i, input, CntWidth bits: timeout budget in ticks, sampled at each AW handshake.
REQ-009 SHALL have ports aw_valid_i, aw_ready_i (1 bit each) and aw_id_i (AxiIdWidth bits), all inputs: the observed AW handshake.
REQ-010 SHALL have ports b_valid_i, b_ready_i (1 bit each) and b_id_i (AxiIdWidth bits), all inputs: the observed B handshake.
REQ-011 SHALL have port accept_o, output, 1 bit: a new AW carrying aw_id_i can be tracked this cycle.
REQ-012 SHALL have port clear_i, input, 1 bit: clears all sticky flags.
REQ-013 SHALL have ports timeout_o (1 bit) and timeout_id_o (AxiIdWidth bits), outputs: a timeout is pending, and the ID of the lowest-index expired entry.
REQ-014 SHALL have ports overflow_o, unexpected_o and busy_o, outputs, 1 bit each: sticky untracked-AW error, sticky unmatched-B error, and any transaction outstanding.

Function
REQ-015 SHALL keep an ID table of MaxUniqIds entries; each entry holds a valid bit, an ID, an outstanding count (0..MaxTxnsPerId), and MaxTxnsPerId slots arranged as a ring.
REQ-016 Each slot SHALL hold a CntWidth-bit remaining-budget counter and a sticky expired bit.
REQ-017 The prescaler SHALL count 0..PrescalerDiv-1 and wrap to 0; tick is high for one cycle when the count equals PrescalerDiv-1.
REQ-018 accept_o SHALL be combinational: high if a valid entry matches aw_id_i with count below MaxTxnsPerId, or if no valid entry matches and a free entry exists.
REQ-019 An AW handshake with accept_o high SHALL write budget_i into the tail slot of the matching entry (otherwise the lowest-index free entry, which is then allocated) and increment the count on the next edge.
REQ-020 An AW handshake with accept_o low SHALL not be tracked and SHALL set overflow_o.
REQ-021 On a tick, every occupied slot whose counter is nonzero SHALL decrement by 1.
REQ-022 On a tick, an occupied slot whose counter is 0 SHALL set its expired bit; a budget of 0 therefore expires at the first tick after capture.
REQ-023 A B handshake whose ID matches a valid entry SHALL retire that entry's head slot, clearing its expired bit, and decrement the count; when the count reaches 0 the entry SHALL be freed.
REQ-024 A B handshake whose ID matches no valid entry SHALL set unexpected_o and change no other state.
REQ-025 When AW and B handshakes for the same ID occur in the same cycle, both SHALL be applied and the count SHALL be unchanged.
REQ-026 A full entry with a simultaneous B SHALL still drive accept_o low in that cycle.
REQ-027 Tick, capture and retire in the same cycle SHALL apply in this order: capture loads budget_i undecremented, and a retired slot is not marked expired.
REQ-028 timeout_o SHALL equal the OR of all expired bits; timeout_id_o SHALL be the ID of the lowest-index entry holding an expired slot, and 0 when none.
REQ-029 clear_i SHALL clear all expired bits, overflow_o and unexpected_o; an error event in the same cycle SHALL win over clear_i.
REQ-030 busy_o SHALL be high whenever any entry is valid.

Reset
REQ-031 On rst_ni low, all of the following SHALL reset asynchronously, including mid-transaction: entries invalid, counts and pointers 0, counters and expired bits 0, prescaler 0, overflow_o/unexpected_o/timeout_o/busy_o 0, timeout_id_o 0.
REQ-032 accept_o SHALL be high during and immediately after reset.
REQ-033 Handshakes coinciding with reset SHALL be dropped.

Structure
REQ-034 The parameter defaults and the slot and entry struct typedefs SHALL live in the shared monitor package.
REQ-035 The prescaler SHALL be a separate sub-module, txn_tick_prescaler, with clk_i, rst_ni and tick_o ports.

Verification
REQ-036 Budget 3, PrescalerDiv 4, one AW with ID 5 and no B -> timeout_o rises on the 4th tick (cycle 16 after AW), with timeout_id_o = 5.
REQ-037 Four AWs with ID 2 -> accept_o goes low; a fifth AW sets overflow_o; one B with ID 2 -> accept_o returns high.
REQ-038 AWs with IDs 1 and 3 fill both entries; an AW with ID 4 -> accept_o low; B 1 frees entry 0 -> ID 4 is allocated to entry 0.
REQ-039 B with ID 7 and nothing outstanding -> unexpected_o = 1; pulse clear_i -> 0.
REQ-040 Same-cycle AW and B with ID 2 while count is 2 -> count stays 2 and the head slot retires.
REQ-041 rst_ni pulsed low with 3 transactions outstanding -> busy_o = 0, accept_o = 1, and a subsequent B sets unexpected_o.

Source files
------------

// File: rtl/axi_txn_timeout_tracker_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_txn_timeout_tracker_pkg
// Description : Shared types, defaults and helpers for the AXI write
//               transaction timeout monitor.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_txn_timeout_tracker_pkg;

   // Default shape of the monitor. The table storage types below are sized
   // from these values, so a configuration change starts here.
   localparam int unsigned DefMaxUniqIds   = 2;
   localparam int unsigned DefMaxTxnsPerId = 4;
   localparam int unsigned DefCntWidth     = 10;
   localparam int unsigned DefPrescalerDiv = 64;
   localparam int unsigned DefAxiIdWidth   = 6;

   localparam int unsigned SlotIdxW = (DefMaxTxnsPerId > 1) ? $clog2(DefMaxTxnsPerId) : 1;
   localparam int unsigned TxnCntW  = $clog2(DefMaxTxnsPerId + 1);

   // One outstanding transaction: remaining ticks plus sticky expiry.
   typedef struct packed {
      logic                   expired;
      logic [DefCntWidth-1:0] cnt;
   } slot_t;

   // One tracked ID with its ring of outstanding transactions.
   typedef struct packed {
      logic                               valid;
      logic [DefAxiIdWidth-1:0]           id;
      logic [TxnCntW-1:0]                 count;
      logic [SlotIdxW-1:0]                head;
      logic [SlotIdxW-1:0]                tail;
      slot_t [DefMaxTxnsPerId-1:0]        slots;
   } entry_t;

   // Ring pointer advance with wrap at an arbitrary depth.
   function automatic logic [SlotIdxW-1:0] ring_inc(input logic [SlotIdxW-1:0] p,
                                                     input int unsigned         depth);
      if (32'(p) + 32'd1 >= depth) return '0;
      else                         return p + 1'b1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/txn_tick_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : txn_tick_prescaler
// Description : Free-running divider producing a one-cycle timeout tick every
//               PrescalerDiv clocks.
// Revision    : 1.0 - initial release
// ============================================================================
module txn_tick_prescaler
   import axi_txn_timeout_tracker_pkg::*;
#(
   parameter int unsigned PrescalerDiv = DefPrescalerDiv
) (
   input  logic clk_i,
   input  logic rst_ni,
   output logic tick_o
);

   localparam int unsigned PreW = $clog2(PrescalerDiv);

   logic [PreW-1:0] cnt_q;
   logic [PreW-1:0] cnt_d;

   assign tick_o = (cnt_q == PreW'(PrescalerDiv - 1));
   assign cnt_d  = tick_o ? '0 : cnt_q + 1'b1;

   // Divider count register, wraps on the tick cycle.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

endmodule
`default_nettype wire

// File: rtl/axi_txn_timeout_tracker.sv
`default_nettype none
// ============================================================================
// Module      : axi_txn_timeout_tracker
// Description : Passive AXI AW/B monitor. Tracks outstanding writes per ID,
//               counts down a per-transaction budget in prescaled ticks and
//               flags timeouts, untracked AWs and unmatched Bs.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_txn_timeout_tracker
   import axi_txn_timeout_tracker_pkg::*;
#(
   parameter int unsigned MaxUniqIds   = DefMaxUniqIds,
   parameter int unsigned MaxTxnsPerId = DefMaxTxnsPerId,
   parameter int unsigned CntWidth     = DefCntWidth,
   parameter int unsigned PrescalerDiv = DefPrescalerDiv,
   parameter int unsigned AxiIdWidth   = DefAxiIdWidth
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic [CntWidth-1:0]   budget_i,
   input  logic                  aw_valid_i,
   input  logic                  aw_ready_i,
   input  logic [AxiIdWidth-1:0] aw_id_i,
   input  logic                  b_valid_i,
   input  logic                  b_ready_i,
   input  logic [AxiIdWidth-1:0] b_id_i,
   input  logic                  clear_i,
   output logic                  accept_o,
   output logic                  timeout_o,
   output logic [AxiIdWidth-1:0] timeout_id_o,
   output logic                  overflow_o,
   output logic                  unexpected_o,
   output logic                  busy_o
);

   localparam int unsigned EntIdxW = (MaxUniqIds > 1) ? $clog2(MaxUniqIds) : 1;

   entry_t [MaxUniqIds-1:0] ent_q, ent_d;
   logic                    tick;
   logic                    aw_hs, b_hs;
   logic                    aw_hit, b_hit, free_any;
   logic                    aw_fire, b_fire;
   logic [EntIdxW-1:0]      aw_idx, b_idx, free_idx, aw_tgt;
   logic                    ovf_q, unexp_q;

   txn_tick_prescaler #(
      .PrescalerDiv (PrescalerDiv)
   ) u_prescaler (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .tick_o (tick)
   );

   // A slot is occupied when it sits within count positions of the head.
   function automatic logic slot_busy(input entry_t e, input int k);
      int h;
      int off;
      h   = int'(e.head);
      off = (k >= h) ? (k - h) : (k + int'(MaxTxnsPerId) - h);
      return off < int'(e.count);
   endfunction

   // ID lookups for AW and B, plus lowest free entry (descending loop keeps the lowest index).
   always_comb begin
      aw_hit   = 1'b0;
      aw_idx   = '0;
      b_hit    = 1'b0;
      b_idx    = '0;
      free_any = 1'b0;
      free_idx = '0;
      for (int i = MaxUniqIds - 1; i >= 0; i--) begin
         if (ent_q[i].valid && (ent_q[i].id == aw_id_i)) begin
            aw_hit = 1'b1;
            aw_idx = EntIdxW'(i);
         end
         if (ent_q[i].valid && (ent_q[i].id == b_id_i)) begin
            b_hit = 1'b1;
            b_idx = EntIdxW'(i);
         end
         if (!ent_q[i].valid) begin
            free_any = 1'b1;
            free_idx = EntIdxW'(i);
         end
      end
   end

   // Acceptance looks only at registered state, so a same-cycle B cannot open a full entry.
   assign accept_o = aw_hit ? (ent_q[aw_idx].count < TxnCntW'(MaxTxnsPerId)) : free_any;
   assign aw_hs    = aw_valid_i && aw_ready_i;
   assign b_hs     = b_valid_i && b_ready_i;
   assign aw_fire  = aw_hs && accept_o;
   assign b_fire   = b_hs && b_hit;
   assign aw_tgt   = aw_hit ? aw_idx : free_idx;

   // Table update in order: clear, tick, retire head, capture tail, recount.
   always_comb begin
      ent_d = ent_q;
      for (int i = 0; i < MaxUniqIds; i++) begin
         for (int k = 0; k < MaxTxnsPerId; k++) begin
            if (clear_i) ent_d[i].slots[k].expired = 1'b0;
            if (tick && slot_busy(ent_q[i], k)) begin
               if (ent_q[i].slots[k].cnt != '0)
                  ent_d[i].slots[k].cnt = ent_q[i].slots[k].cnt - 1'b1;
               else
                  ent_d[i].slots[k].expired = 1'b1;
            end
         end
      end
      if (b_fire) begin
         ent_d[b_idx].slots[ent_q[b_idx].head] = '0;
         ent_d[b_idx].head = ring_inc(ent_q[b_idx].head, MaxTxnsPerId);
      end
      if (aw_fire) begin
         ent_d[aw_tgt].slots[ent_q[aw_tgt].tail].expired = 1'b0;
         ent_d[aw_tgt].slots[ent_q[aw_tgt].tail].cnt     = budget_i;
         ent_d[aw_tgt].tail = ring_inc(ent_q[aw_tgt].tail, MaxTxnsPerId);
         ent_d[aw_tgt].id   = aw_id_i;
      end
      for (int i = 0; i < MaxUniqIds; i++) begin
         if ((aw_fire && int'(aw_tgt) == i) && !(b_fire && int'(b_idx) == i))
            ent_d[i].count = ent_q[i].count + 1'b1;
         else if (!(aw_fire && int'(aw_tgt) == i) && (b_fire && int'(b_idx) == i))
            ent_d[i].count = ent_q[i].count - 1'b1;
         ent_d[i].valid = (ent_d[i].count != '0);
      end
   end

   // ID table register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) ent_q <= '0;
      else         ent_q <= ent_d;
   end

   // Sticky error flags; a new error event takes priority over clear.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ovf_q   <= 1'b0;
         unexp_q <= 1'b0;
      end else begin
         if (aw_hs && !accept_o) ovf_q <= 1'b1;
         else if (clear_i)       ovf_q <= 1'b0;
         if (b_hs && !b_hit)     unexp_q <= 1'b1;
         else if (clear_i)       unexp_q <= 1'b0;
      end
   end

   // Timeout reporting (lowest entry wins) and busy summary.
   always_comb begin
      timeout_o    = 1'b0;
      timeout_id_o = '0;
      busy_o       = 1'b0;
      for (int i = MaxUniqIds - 1; i >= 0; i--) begin
         busy_o = busy_o | ent_q[i].valid;
         for (int k = 0; k < MaxTxnsPerId; k++) begin
            if (ent_q[i].slots[k].expired) begin
               timeout_o    = 1'b1;
               timeout_id_o = ent_q[i].id;
            end
         end
      end
   end

   assign overflow_o   = ovf_q;
   assign unexpected_o = unexp_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_txn_timeout_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_txn_timeout_tracker
// Description : Directed self-checking bench for axi_txn_timeout_tracker,
//               run with a 4-cycle tick to keep timeouts short.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_txn_timeout_tracker;

   localparam int unsigned Div = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [9:0] budget;
   logic       aw_valid, aw_ready, b_valid, b_ready, clear;
   logic [5:0] aw_id, b_id;
   logic       accept, timeout, overflow, unexpected, busy;
   logic [5:0] timeout_id;

   int checks = 0;
   int passes = 0;
   int pcnt;

   axi_txn_timeout_tracker #(
      .MaxUniqIds   (2),
      .MaxTxnsPerId (4),
      .CntWidth     (10),
      .PrescalerDiv (Div),
      .AxiIdWidth   (6)
   ) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .budget_i     (budget),
      .aw_valid_i   (aw_valid),
      .aw_ready_i   (aw_ready),
      .aw_id_i      (aw_id),
      .b_valid_i    (b_valid),
      .b_ready_i    (b_ready),
      .b_id_i       (b_id),
      .clear_i      (clear),
      .accept_o     (accept),
      .timeout_o    (timeout),
      .timeout_id_o (timeout_id),
      .overflow_o   (overflow),
      .unexpected_o (unexpected),
      .busy_o       (busy)
   );

   always #5 clk = ~clk;

   // Reference prescaler phase, used only to place the timed AW on a tick edge.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)              pcnt <= 0;
      else if (pcnt == Div-1)  pcnt <= 0;
      else                     pcnt <= pcnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_aw(input logic [5:0] id, input logic [9:0] bud);
      aw_valid = 1'b1; aw_id = id; budget = bud;
      step();
      aw_valid = 1'b0;
   endtask

   task automatic do_b(input logic [5:0] id);
      b_valid = 1'b1; b_id = id;
      step();
      b_valid = 1'b0;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      step();
      clear = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset with handshakes active; they must leave no trace.
      rst_n = 1'b0; aw_ready = 1'b1; b_ready = 1'b1; clear = 1'b0;
      aw_valid = 1'b1; aw_id = 6'd3; b_valid = 1'b1; b_id = 6'd3; budget = 10'd5;
      repeat (3) @(negedge clk);
      check("rst_accept",     accept,     1);
      check("rst_busy",       busy,       0);
      check("rst_timeout",    timeout,    0);
      check("rst_timeout_id", timeout_id, 0);
      check("rst_overflow",   overflow,   0);
      check("rst_unexpected", unexpected, 0);
      rst_n = 1'b1; aw_valid = 1'b0; b_valid = 1'b0;
      step();
      check("post_rst_busy",   busy,       0);
      check("post_rst_accept", accept,     1);
      check("post_rst_unexp",  unexpected, 0);

      // Unmatched B, clear, and error-over-clear priority.
      do_b(6'd7);
      check("unexp_set",  unexpected, 1);
      check("unexp_busy", busy,       0);
      do_clear();
      check("unexp_clr",  unexpected, 0);
      b_valid = 1'b1; b_id = 6'd7; clear = 1'b1;
      step();
      b_valid = 1'b0; clear = 1'b0;
      check("unexp_beats_clear", unexpected, 1);
      do_clear();

      // Fill ID 2, overflow, and a same-cycle B against a full entry.
      for (int n = 0; n < 4; n++) begin
         aw_id = 6'd2;
         #1 check($sformatf("fill_accept_%0d", n), accept, 1);
         do_aw(6'd2, 10'd1000);
      end
      aw_id = 6'd2;
      #1 check("full_accept", accept, 0);
      do_aw(6'd2, 10'd1000);
      check("overflow_set", overflow, 1);
      check("full_busy",    busy,     1);
      do_b(6'd2);
      aw_id = 6'd2;
      #1 check("after_b_accept", accept, 1);
      do_aw(6'd2, 10'd1000);
      do_clear();
      check("overflow_clr", overflow, 0);
      aw_valid = 1'b1; aw_id = 6'd2; budget = 10'd1000; b_valid = 1'b1; b_id = 6'd2;
      #1 check("full_with_b_accept", accept, 0);
      step();
      aw_valid = 1'b0; b_valid = 1'b0;
      check("full_with_b_overflow", overflow, 1);
      aw_id = 6'd2;
      #1 check("full_with_b_after", accept, 1);
      repeat (3) do_b(6'd2);
      check("drain_busy", busy, 0);
      do_clear();

      // Same-cycle AW and B with two outstanding: head retires, count holds.
      do_aw(6'd2, 10'd0);
      do_aw(6'd2, 10'd1000);
      for (int n = 0; n < 12 && timeout !== 1'b1; n++) step();
      check("samecyc_expired",    timeout,    1);
      check("samecyc_expired_id", timeout_id, 2);
      aw_valid = 1'b1; aw_id = 6'd2; budget = 10'd1000; b_valid = 1'b1; b_id = 6'd2;
      #1 check("samecyc_accept", accept, 1);
      step();
      aw_valid = 1'b0; b_valid = 1'b0;
      check("samecyc_head_retired", timeout, 0);
      do_b(6'd2);
      check("samecyc_busy_after_1b", busy, 1);
      do_b(6'd2);
      check("samecyc_busy_after_2b", busy, 0);
      do_b(6'd2);
      check("samecyc_extra_b_unexp", unexpected, 1);
      do_clear();

      // Two IDs fill the table; freeing entry 0 lets a new ID take it.
      do_aw(6'd1, 10'd1000);
      do_aw(6'd3, 10'd0);
      aw_id = 6'd4;
      #1 check("table_full_accept", accept, 0);
      aw_id = 6'd1;
      #1 check("table_hit_accept", accept, 1);
      for (int n = 0; n < 12 && timeout !== 1'b1; n++) step();
      check("id3_timeout_id", timeout_id, 3);
      do_b(6'd1);
      aw_id = 6'd4;
      #1 check("freed_accept", accept, 1);
      do_aw(6'd4, 10'd0);
      for (int n = 0; n < 12 && timeout_id !== 6'd4; n++) step();
      check("id4_in_entry0", timeout_id, 4);
      do_b(6'd3);
      do_b(6'd4);
      check("alloc_drain_busy",    busy,    0);
      check("alloc_drain_timeout", timeout, 0);
      check("alloc_no_overflow",   overflow, 0);

      // Budget 3 captured on a tick edge: expiry exactly 16 cycles later.
      for (int n = 0; n < Div && pcnt != Div-1; n++) step();
      do_aw(6'd5, 10'd3);
      for (int n = 1; n <= 16; n++) begin
         step();
         check($sformatf("budget3_cyc%0d", n), timeout, (n == 16) ? 1 : 0);
      end
      check("budget3_id", timeout_id, 5);
      do_clear();
      check("budget3_cleared", timeout, 0);
      repeat (3) step();
      check("budget3_reexpire", timeout, 1);
      do_b(6'd5);
      check("budget3_retire_timeout", timeout, 0);
      check("budget3_retire_busy",    busy,    0);

      // Asynchronous reset with three transactions outstanding.
      do_aw(6'd1, 10'd1000);
      do_aw(6'd1, 10'd1000);
      do_aw(6'd2, 10'd1000);
      check("pre_rst_busy", busy, 1);
      #2 rst_n = 1'b0;
      #1 check("async_rst_busy",   busy,   0);
      check("async_rst_accept", accept, 1);
      @(negedge clk);
      rst_n = 1'b1;
      do_b(6'd1);
      check("post_rst_b_unexp", unexpected, 1);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
`default_nettype wire
